// File: rtl/ps2kbd_decoder_if.sv
// Bundle of the FIFO-side and event-side handshake signals of the PS/2
// keyboard decoder. The decoder connects through the slave modport; the
// environment (FIFO plus event consumer) connects through the master modport.
interface ps2kbd_decoder_if;
  logic [7:0] data;
  logic       ready;
  logic       nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_shift;
  logic       evt_caps;

  modport slave (
    input  data, ready, evt_ready,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_shift, evt_caps
  );

  modport master (
    output data, ready, evt_ready,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_break, evt_shift, evt_caps
  );
endinterface

// File: rtl/ps2kbd_decoder.sv
// PS/2 keyboard scancode decoder. Pops scancode bytes from a PS/2 FIFO,
// strips the E0/F0 prefixes and presents one key event at a time through a
// valid/ready slot. Tracks shift and caps-lock, filters typematic repeats
// of the held key and counts accepted key presses.
module ps2kbd_decoder #(
  parameter int CNT_W         = 8,
  parameter int REPEAT_FILTER = 1
) (
  input  logic             clk,
  input  logic             clrn,
  ps2kbd_decoder_if.slave  bus,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             blockPop_q;
  logic             evtValid_q;
  logic [7:0]       evtCode_q;
  logic             evtExt_q;
  logic             evtBreak_q;
  logic             evtShift_q;
  logic             evtCaps_q;
  logic [CNT_W-1:0] pressCnt_q;
  logic             err_q;
  logic             heldValid_q;
  logic [7:0]       heldCode_q;
  logic             heldExt_q;
  logic             shiftL_q;
  logic             shiftR_q;
  logic             caps_q;

  logic slotFree;
  logic popNow;
  logic isErr;
  logic isPrefix;
  logic curExt;
  logic curBrk;
  logic heldMatch;
  logic suppress;
  logic emit;

  // blockPop_q resets high so no pop can happen during reset or in the
  // first cycle after it, and it also keeps the strobe from being low twice
  // in a row. The slot counts as free when it is empty or being drained.
  assign slotFree = !evtValid_q || bus.evt_ready;
  assign popNow   = bus.ready && !blockPop_q && slotFree;

  assign bus.nextdata_n = ~popNow;
  assign bus.evt_valid  = evtValid_q;
  assign bus.evt_code   = evtCode_q;
  assign bus.evt_ext    = evtExt_q;
  assign bus.evt_break  = evtBreak_q;
  assign bus.evt_shift  = evtShift_q;
  assign bus.evt_caps   = evtCaps_q;
  assign press_cnt      = pressCnt_q;
  assign err            = err_q;

  // Classify the byte at the head of the FIFO against the parser state.
  always_comb begin
    isErr     = (bus.data == 8'h00) || (bus.data == 8'hFF);
    curExt    = (state_q == EXT) || (state_q == EXTBRK);
    curBrk    = (state_q == BRK) || (state_q == EXTBRK);
    isPrefix  = ((state_q == IDLE) && ((bus.data == 8'hE0) || (bus.data == 8'hF0))) ||
                ((state_q == EXT) && (bus.data == 8'hF0));
    heldMatch = heldValid_q && (heldCode_q == bus.data) && (heldExt_q == curExt);
    suppress  = (REPEAT_FILTER != 0) && !curBrk && heldMatch;
    emit      = !isErr && !isPrefix && !suppress;
    state_d   = IDLE;
    if (!isErr) begin
      if ((state_q == IDLE) && (bus.data == 8'hE0))      state_d = EXT;
      else if ((state_q == IDLE) && (bus.data == 8'hF0)) state_d = BRK;
      else if ((state_q == EXT) && (bus.data == 8'hF0))  state_d = EXTBRK;
    end
  end

  // Parser, event slot, modifier tracking and press counter; everything
  // advances only on a pop, so a stalled slot freezes all of it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      blockPop_q  <= 1'b1;
      evtValid_q  <= 1'b0;
      evtCode_q   <= 8'h00;
      evtExt_q    <= 1'b0;
      evtBreak_q  <= 1'b0;
      evtShift_q  <= 1'b0;
      evtCaps_q   <= 1'b0;
      pressCnt_q  <= '0;
      err_q       <= 1'b0;
      heldValid_q <= 1'b0;
      heldCode_q  <= 8'h00;
      heldExt_q   <= 1'b0;
      shiftL_q    <= 1'b0;
      shiftR_q    <= 1'b0;
      caps_q      <= 1'b0;
    end else begin
      blockPop_q <= popNow;
      err_q      <= 1'b0;
      if (evtValid_q && bus.evt_ready) begin
        evtValid_q <= 1'b0;
      end
      if (popNow) begin
        state_q <= state_d;
        if (isErr) begin
          err_q <= 1'b1;
        end
        if (emit) begin
          evtValid_q <= 1'b1;
          evtCode_q  <= bus.data;
          evtExt_q   <= curExt;
          evtBreak_q <= curBrk;
          evtShift_q <= shiftL_q || shiftR_q;
          evtCaps_q  <= caps_q;
          if (!curBrk) begin
            pressCnt_q  <= pressCnt_q + CNT_ONE;
            heldValid_q <= 1'b1;
            heldCode_q  <= bus.data;
            heldExt_q   <= curExt;
            if (!curExt && (bus.data == 8'h58)) begin
              caps_q <= ~caps_q;
            end
          end else if (heldMatch) begin
            heldValid_q <= 1'b0;
          end
          if (!curExt && (bus.data == 8'h12)) begin
            shiftL_q <= !curBrk;
          end
          if (!curExt && (bus.data == 8'h59)) begin
            shiftR_q <= !curBrk;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2kbd_decoder.sv
// Scoreboard testbench for ps2kbd_decoder: a FIFO model feeds scancode
// bytes, directed scenarios queue the expected key events, and a separate
// monitor compares every accepted event against the queue.
module tb_ps2kbd_decoder;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       shift;
    logic       caps;
  } evt_t;

  logic             clk = 1'b0;
  logic             clrn;
  logic [CNT_W-1:0] press_cnt;
  logic             err;

  ps2kbd_decoder_if bus ();

  ps2kbd_decoder #(
    .CNT_W(CNT_W),
    .REPEAT_FILTER(1)
  ) dut (
    .clk(clk),
    .clrn(clrn),
    .bus(bus),
    .press_cnt(press_cnt),
    .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] fifoQ[$];
  evt_t       expQ[$];
  int         rdIdx = 0;
  int         expIdx = 0;
  int         popCount = 0;
  int         dblPop = 0;
  int         errCount = 0;
  int         checks = 0;
  int         failures = 0;
  logic       evtReadyDrv = 1'b1;
  logic       prevPop = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifoQ.push_back(b);
  endtask

  task automatic expectEvt(input logic [7:0] code, input logic ext, input logic brk,
                           input logic shift, input logic caps);
    evt_t e;
    e.code  = code;
    e.ext   = ext;
    e.brk   = brk;
    e.shift = shift;
    e.caps  = caps;
    expQ.push_back(e);
  endtask

  task automatic doReset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (!(rdIdx == fifoQ.size() && expIdx == expQ.size() && !bus.evt_valid) && n < 600) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 600) checkOutput({name, " drain timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #3;
  endtask

  // FIFO model: present the head byte each cycle and retire it when the
  // decoder strobes nextdata_n low.
  always @(negedge clk) begin
    bus.ready     = (rdIdx < fifoQ.size());
    bus.data      = (rdIdx < fifoQ.size()) ? fifoQ[rdIdx] : 8'h00;
    bus.evt_ready = evtReadyDrv;
    #1;
    if (bus.nextdata_n === 1'b0) begin
      popCount++;
      if (prevPop) dblPop++;
      if (rdIdx < fifoQ.size()) rdIdx++;
      prevPop = 1'b1;
    end else begin
      prevPop = 1'b0;
    end
  end

  // Monitor: every event taken by the consumer is popped from the scoreboard.
  always @(negedge clk) begin
    #2;
    if (clrn === 1'b1) begin
      if (err === 1'b1) errCount++;
      if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
        if (expIdx >= expQ.size()) begin
          checkOutput("unexpected event", {20'd0, bus.evt_code, bus.evt_ext, bus.evt_break,
                      bus.evt_shift, bus.evt_caps}, 32'hFFFFFFFF);
        end else begin
          checkOutput("event fields", {20'd0, bus.evt_code, bus.evt_ext, bus.evt_break,
                      bus.evt_shift, bus.evt_caps}, {20'd0, expQ[expIdx]});
          expIdx++;
        end
      end
    end
  end

  initial begin
    int base;
    int errBase;
    int stallBad;
    int n;

    clrn = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checkOutput("reset nextdata_n", 32'(bus.nextdata_n), 32'd1);
    checkOutput("reset evt_valid", 32'(bus.evt_valid), 32'd0);
    checkOutput("reset evt_code", 32'(bus.evt_code), 32'h00);
    checkOutput("reset ext/brk/shift/caps",
                {28'd0, bus.evt_ext, bus.evt_break, bus.evt_shift, bus.evt_caps}, 32'd0);
    checkOutput("reset press_cnt", 32'(press_cnt), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    clrn = 1'b1;

    // Plain press and release of 1C
    base = popCount;
    applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
    expectEvt(8'h1C, 0, 0, 0, 0);
    expectEvt(8'h1C, 0, 1, 0, 0);
    waitDrain("basic");
    checkOutput("basic press_cnt", 32'(press_cnt), 32'd1);
    checkOutput("basic pops", 32'(popCount - base), 32'd3);

    // Extended key press and release
    doReset();
    base = popCount;
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    expectEvt(8'h75, 1, 0, 0, 0);
    expectEvt(8'h75, 1, 1, 0, 0);
    waitDrain("extended");
    checkOutput("extended pops", 32'(popCount - base), 32'd5);
    checkOutput("extended press_cnt", 32'(press_cnt), 32'd1);

    // Shift and caps-lock tracking
    doReset();
    applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'hF0);
    applyStimulus(8'h12); applyStimulus(8'h58); applyStimulus(8'h1C);
    expectEvt(8'h12, 0, 0, 0, 0);
    expectEvt(8'h1C, 0, 0, 1, 0);
    expectEvt(8'h12, 0, 1, 1, 0);
    expectEvt(8'h58, 0, 0, 0, 0);
    expectEvt(8'h1C, 0, 0, 0, 1);
    waitDrain("modifiers");
    checkOutput("modifiers press_cnt", 32'(press_cnt), 32'd4);

    // Typematic repeats are dropped
    doReset();
    base = popCount;
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    expectEvt(8'h1C, 0, 0, 0, 0);
    expectEvt(8'h1C, 0, 1, 0, 0);
    waitDrain("repeat");
    checkOutput("repeat press_cnt", 32'(press_cnt), 32'd1);
    checkOutput("repeat pops", 32'(popCount - base), 32'd5);

    // Counter wraps after 17 presses at CNT_W=4
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(8'h20 + 8'(i));
      applyStimulus(8'hF0);
      applyStimulus(8'h20 + 8'(i));
      expectEvt(8'h20 + 8'(i), 0, 0, 0, 0);
      expectEvt(8'h20 + 8'(i), 0, 1, 0, 0);
    end
    waitDrain("wrap");
    checkOutput("wrap press_cnt", 32'(press_cnt), 32'd1);

    // Consumer stall: the slot holds and nothing is popped
    doReset();
    evtReadyDrv = 1'b0;
    @(negedge clk);
    applyStimulus(8'h1C); applyStimulus(8'h2C);
    expectEvt(8'h1C, 0, 0, 0, 0);
    expectEvt(8'h2C, 0, 0, 0, 0);
    n = 0;
    while (bus.evt_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("stall evt_valid", 32'(bus.evt_valid), 32'd1);
    base = popCount;
    stallBad = 0;
    repeat (10) begin
      @(negedge clk);
      #3;
      if (bus.evt_valid !== 1'b1 || bus.evt_code !== 8'h1C || bus.evt_break !== 1'b0 ||
          bus.evt_ext !== 1'b0) stallBad++;
    end
    checkOutput("stall pops", 32'(popCount - base), 32'd0);
    checkOutput("stall fields stable", 32'(stallBad), 32'd0);
    evtReadyDrv = 1'b1;
    waitDrain("stall");
    checkOutput("stall press_cnt", 32'(press_cnt), 32'd2);

    // Error byte discards the pending E0
    doReset();
    errBase = errCount;
    applyStimulus(8'hE0); applyStimulus(8'hFF); applyStimulus(8'h1C);
    expectEvt(8'h1C, 0, 0, 0, 0);
    waitDrain("error");
    checkOutput("error pulse cycles", 32'(errCount - errBase), 32'd1);

    // Reset in the middle of an extended sequence
    base = popCount;
    applyStimulus(8'hE0);
    n = 0;
    while (popCount == base && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("midreset E0 popped", 32'(popCount - base), 32'd1);
    @(negedge clk);
    clrn = 1'b0;
    #1;
    checkOutput("midreset evt_code", 32'(bus.evt_code), 32'h00);
    checkOutput("midreset press_cnt", 32'(press_cnt), 32'd0);
    checkOutput("midreset nextdata_n", 32'(bus.nextdata_n), 32'd1);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    applyStimulus(8'h1C);
    expectEvt(8'h1C, 0, 0, 0, 0);
    waitDrain("midreset");
    checkOutput("midreset press_cnt after", 32'(press_cnt), 32'd1);

    checkOutput("nextdata_n never low twice", 32'(dblPop), 32'd0);
    checkOutput("all expected events seen", 32'(expIdx), 32'(expQ.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2kbd_decoder.md
PS2KBD_DECODER -- requirements
Module: ps2kbd_decoder

Interface
REQ-001 Parameter CNT_W, default 8, sets the press-counter width; legal range 4..16.
REQ-002 Parameter REPEAT_FILTER, default 1; when 1, typematic repeats are suppressed.
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port clrn, input, 1, reset; asynchronous, active-low.
REQ-005 Port data, input, 8, scancode byte at the head of the PS/2 FIFO.
REQ-006 Port ready, input, 1, FIFO non-empty; data is valid while ready=1.
REQ-007 Port nextdata_n, output, 1, active-low single-cycle FIFO pop strobe.
REQ-008 Port evt_valid, output, 1, key event available.
REQ-009 Port evt_ready, input, 1, consumer accepts the event.
REQ-010 Port evt_code, output, 8, make code of the event (F0/E0 prefixes stripped).
REQ-011 Port evt_ext, output, 1, event carried the E0 prefix.
REQ-012 Port evt_break, output, 1, 1 = key release, 0 = key press.
REQ-013 Port evt_shift, output, 1, either shift held when the event was formed.
REQ-014 Port evt_caps, output, 1, caps-lock state when the event was formed.
REQ-015 Port press_cnt, output, CNT_W, count of accepted press events.
REQ-016 Port err, output, 1, one-cycle pulse on a protocol error byte.

Function
REQ-017 Pop rule: nextdata_n=0 for exactly one cycle when ready=1, nextdata_n=1 in the prior cycle, and the event slot is free (evt_valid=0, or evt_valid=1 with evt_ready=1); the byte on data is latched in that same cycle.
REQ-018 nextdata_n shall never be low on two consecutive cycles.
REQ-019 Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0,F0 seen).
REQ-020 Transitions: IDLE+E0 -> EXT; IDLE+F0 -> BRK; EXT+F0 -> EXTBRK; any other byte forms an event and returns the FSM to IDLE.
REQ-021 Event fields: ext=1 if formed from EXT or EXTBRK; break=1 if formed from BRK or EXTBRK.
REQ-022 Latency: byte popped in cycle N -> evt_valid=1 with fields stable in cycle N+1.
REQ-023 evt_valid and all evt_* fields shall hold until the cycle evt_valid=1 and evt_ready=1; evt_valid drops the following cycle unless a new event is loaded in the same cycle.
REQ-024 Prefix bytes (E0, F0) shall produce no event.
REQ-025 Byte 00 or FF in any state: err=1 for one cycle, FSM -> IDLE, no event, pending prefixes discarded.
REQ-026 Held-key register (code, ext): set on an emitted press, cleared on a release whose code and ext match it.
REQ-027 With REPEAT_FILTER=1, a press matching the held-key register is popped and dropped: no event, no count, no caps toggle.
REQ-028 Shift tracking: make 12 or 59 without ext sets that side's flag; the matching break clears it; evt_shift = OR of both flags before the current byte is applied.
REQ-029 Caps lock: a non-suppressed press of 58 without ext toggles caps after the event is formed; evt_caps reflects the pre-toggle state.
REQ-030 press_cnt increments by 1 per emitted press event and wraps from 2^CNT_W-1 to 0; breaks do not count.
REQ-031 While the event slot is full and evt_ready=0, no pop occurs; the FSM, flags and counter hold.

Reset
REQ-032 clrn=0 asynchronously forces: nextdata_n=1, evt_valid=0, evt_code=00, evt_ext=0, evt_break=0, evt_shift=0, evt_caps=0, press_cnt=0, err=0, FSM=IDLE, held-key and shift flags cleared.
REQ-033 Reset asserted mid-sequence (e.g. after E0) shall discard the partial sequence; the first byte after release is parsed from IDLE.

Verification
REQ-034 FIFO bytes 1C, F0, 1C, evt_ready=1 -> events {1C, ext0, brk0}, {1C, ext0, brk1}; press_cnt=1; nextdata_n low exactly 3 single cycles.
REQ-035 Bytes E0, 75, E0, F0, 75 -> events {75, ext1, brk0}, {75, ext1, brk1}; no event for any prefix byte.
REQ-036 Bytes 12, 1C, F0, 12, 58, 1C -> 1C press with shift=1; 58 press with caps=0; second 1C press with shift=0, caps=1; press_cnt=4.
REQ-037 REPEAT_FILTER=1, bytes 1C, 1C, 1C, F0, 1C -> one press event and one release; press_cnt=1; 5 pops.
REQ-038 CNT_W=4, 17 distinct press/release pairs -> press_cnt=1 (wrap); evt_ready=0 for 10 cycles with ready=1 -> no pop, event fields stable.
REQ-039 Bytes E0, FF, 1C -> err pulse of one cycle, then event {1C, ext0, brk0}; clrn pulsed low after E0 in a rerun -> outputs at reset values, next 1C parsed without ext.
